// File: rtl/sipo_rx.sv
// sipo_rx: serial-to-parallel receiver for the MSB-first data/clock link.
// ser_clk and ser_data are oversampled on clk through equal-depth synchronizers.
// One bit is captured per synchronized ser_clk rising edge. Each WIDTH-bit word
// goes to a one-entry valid/ready holding register.
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   enable          receiver armed; serial edges ignored and partial word cleared when low
//   ser_clk         serial clock (asynchronous, idles low)
//   ser_data        serial data, stable across ser_clk rising edge
//   word_data       received word, MSB = first bit received
//   word_valid      word_data holds an unread word
//   word_ready      consumer accept
//   overflow        pulse: completed word dropped, holding register full
//   frame_err       pulse: partial word aborted by timeout
//   bit_cnt         bits captured in the current word (debug)
module sipo_rx #(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  input  logic                         ser_clk,
  input  logic                         ser_data,
  output logic [WIDTH-1:0]             word_data,
  output logic                         word_valid,
  input  logic                         word_ready,
  output logic                         overflow,
  output logic                         frame_err,
  output logic [$clog2(WIDTH+1)-1:0]   bit_cnt
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned FW = $clog2(SYNC_STAGES + 1);
  localparam logic [CW-1:0] LAST_BIT  = CW'(WIDTH - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [FW-1:0] FILL_DONE = FW'(SYNC_STAGES);

  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
  logic                   clk_prev_q, clk_prev_d;
  logic [FW-1:0]          fill_q, fill_d;
  logic                   armed_q, armed_d;
  // Only WIDTH-1 bits are stored; the final bit comes straight from sync_data.
  logic [WIDTH-2:0]       shift_q, shift_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [TW-1:0]          to_q, to_d;
  logic [WIDTH-1:0]       word_q, word_d;
  logic                   valid_q, valid_d;
  logic                   ovf_q, ovf_d;
  logic                   ferr_q, ferr_d;

  logic sync_clk;
  logic sync_data;
  logic rise;
  logic done;

  always_comb begin
    sync_clk    = clk_sync_q[SYNC_STAGES-1];
    sync_data   = data_sync_q[SYNC_STAGES-1];
    // The reset values in the synchronizer are not real line samples. A ser_clk
    // that is already high at reset release must not look like a rising edge.
    // Rises are accepted only after the pipeline holds real samples and a
    // low level has been observed.
    rise        = armed_q & sync_clk & ~clk_prev_q;

    clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], ser_clk};
    data_sync_d = {data_sync_q[SYNC_STAGES-2:0], ser_data};
    clk_prev_d  = sync_clk;
    fill_d      = (fill_q == FILL_DONE) ? fill_q : fill_q + 1'b1;
    armed_d     = armed_q | ((fill_q == FILL_DONE) & ~sync_clk);

    shift_d = shift_q;
    cnt_d   = cnt_q;
    to_d    = to_q;
    done    = 1'b0;
    ferr_d  = 1'b0;

    if (!enable) begin
      shift_d = '0;
      cnt_d   = '0;
      to_d    = '0;
    end else if (rise) begin
      shift_d = (WIDTH-1)'({shift_q, sync_data});
      to_d    = '0;
      if (cnt_q == LAST_BIT) begin
        done  = 1'b1;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (cnt_q == '0) begin
      to_d = '0;
    end else if (to_q == TO_LAST) begin
      shift_d = '0;
      cnt_d   = '0;
      to_d    = '0;
      ferr_d  = 1'b1;
    end else begin
      to_d = to_q + 1'b1;
    end

    word_d  = word_q;
    valid_d = valid_q;
    ovf_d   = 1'b0;
    if (done) begin
      if (!valid_q || word_ready) begin
        word_d  = {shift_q, sync_data};
        valid_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (valid_q && word_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync_q  <= '0;
      data_sync_q <= '0;
      clk_prev_q  <= 1'b0;
      fill_q      <= '0;
      armed_q     <= 1'b0;
      shift_q     <= '0;
      cnt_q       <= '0;
      to_q        <= '0;
      word_q      <= '0;
      valid_q     <= 1'b0;
      ovf_q       <= 1'b0;
      ferr_q      <= 1'b0;
    end else begin
      clk_sync_q  <= clk_sync_d;
      data_sync_q <= data_sync_d;
      clk_prev_q  <= clk_prev_d;
      fill_q      <= fill_d;
      armed_q     <= armed_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      to_q        <= to_d;
      word_q      <= word_d;
      valid_q     <= valid_d;
      ovf_q       <= ovf_d;
      ferr_q      <= ferr_d;
    end
  end

  assign word_data  = word_q;
  assign word_valid = valid_q;
  assign overflow   = ovf_q;
  assign frame_err  = ferr_q;
  assign bit_cnt    = cnt_q;

endmodule

// File: tb/tb_sipo_rx.sv
// tb_sipo_rx: self-checking bench for sipo_rx.
// A cycle-level reference model tracks captured bits arithmetically. It
// schedules each capture at the latency given by the synchronizer depth and
// applies the holding-register rules. Directed sequences and a vector table
// add explicit named checks.
module tb_sipo_rx;

  localparam int WIDTH = 32;
  localparam int SYNC  = 2;
  localparam int TO    = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0;
  logic ser_clk = 1'b0;
  logic ser_data = 1'b0;
  logic word_ready = 1'b0;
  logic [WIDTH-1:0] word_data;
  logic word_valid, overflow, frame_err;
  logic [5:0] bit_cnt;

  always #5 clk = ~clk;

  sipo_rx #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .enable(enable), .ser_clk(ser_clk), .ser_data(ser_data),
    .word_data(word_data), .word_valid(word_valid), .word_ready(word_ready),
    .overflow(overflow), .frame_err(frame_err), .bit_cnt(bit_cnt)
  );

  int tests = 0;
  int fails = 0;
  int edge_no = 0;
  int last_e = 0;
  bit mon_on = 1'b0;
  bit rand_ready = 1'b0;

  typedef struct { int e; logic b; } cap_t;
  cap_t capq[$];

  // reference model state
  logic m_valid = 1'b0, m_ovf = 1'b0, m_ferr = 1'b0;
  logic [WIDTH-1:0] m_data = '0, m_word = '0, m_full = '0;
  int m_cnt = 0, m_last = 0;
  bit m_got, m_done;
  logic m_bit;

  // observation log
  int ovf_seen = 0, ferr_seen = 0, ferr_edge = 0;
  logic [WIDTH-1:0] acc_q[$];

  initial forever begin
    @(posedge clk);
    edge_no = edge_no + 1;
    m_ovf = 1'b0; m_ferr = 1'b0; m_done = 1'b0; m_got = 1'b0; m_bit = 1'b0;
    if (capq.size() > 0 && capq[0].e == edge_no) begin
      m_bit = capq[0].b;
      void'(capq.pop_front());
      m_got = 1'b1;
    end
    if (rst) begin
      capq.delete();
      m_valid = 1'b0; m_data = '0; m_cnt = 0; m_word = '0;
    end else begin
      if (!enable) begin
        m_cnt = 0; m_word = '0;
      end else if (m_got) begin
        m_word = m_word * 2 + WIDTH'(m_bit);
        m_cnt = m_cnt + 1;
        m_last = edge_no;
        if (m_cnt == WIDTH) begin
          m_done = 1'b1; m_full = m_word; m_cnt = 0; m_word = '0;
        end
      end else if (m_cnt > 0 && edge_no - m_last == TO) begin
        m_ferr = 1'b1; m_cnt = 0; m_word = '0;
      end
      if (m_done) begin
        if (!m_valid || word_ready) begin m_valid = 1'b1; m_data = m_full; end
        else m_ovf = 1'b1;
      end else if (m_valid && word_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    #1;
    if (mon_on) begin
      tests++;
      if (word_valid !== m_valid || word_data !== m_data || overflow !== m_ovf ||
          frame_err !== m_ferr || bit_cnt !== 6'(m_cnt)) begin
        fails++;
        $display("FAIL model edge %0d: got v=%b d=%h ovf=%b ferr=%b cnt=%0d, want v=%b d=%h ovf=%b ferr=%b cnt=%0d",
                 edge_no, word_valid, word_data, overflow, frame_err, bit_cnt,
                 m_valid, m_data, m_ovf, m_ferr, m_cnt);
      end
      if (overflow === 1'b1) ovf_seen++;
      if (frame_err === 1'b1) begin ferr_seen++; ferr_edge = edge_no; end
      if (word_valid === 1'b1 && word_ready === 1'b1 && rst === 1'b0) acc_q.push_back(word_data);
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (rand_ready) word_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic idle(input int n);
    repeat (n) begin tick(); ser_clk = 1'b0; ser_data = 1'b0; end
  endtask

  task automatic send_bit(input logic b, input int extra);
    tick(); ser_clk = 1'b0; ser_data = b;
    repeat (extra) tick();
    tick(); ser_clk = 1'b1;
    last_e = edge_no + 1 + SYNC;
    capq.push_back('{e: last_e, b: b});
  endtask

  task automatic send_word(input logic [WIDTH-1:0] w, input bit rnd);
    for (int i = WIDTH - 1; i >= 0; i--)
      send_bit(w[i], rnd ? int'($urandom_range(0, 2)) : 0);
  endtask

  // Waits for word_valid after the last bit; checks latency and value.
  task automatic expect_word(input string name, input logic [31:0] exp);
    int ke;
    bit seen;
    ke = last_e;
    seen = 1'b0;
    for (int n = 0; n < 12 && !seen; n++) begin
      idle(1);
      #1;
      if (word_valid === 1'b1) begin
        seen = 1'b1;
        check({name, " latency edge"}, edge_no, ke);
        check({name, " data"}, word_data, exp);
      end
    end
    if (!seen) begin
      tests++; fails++;
      $display("FAIL %s: word_valid absent after 12 cycles, required value %h", name, exp);
    end
  endtask

  typedef struct { logic [31:0] tx; logic [31:0] exp; } vec_t;
  vec_t vecs[6];

  initial begin
    int o0, f0;
    vecs[0] = '{tx: 32'hCAFEF00D, exp: 32'hCAFEF00D};
    vecs[1] = '{tx: 32'h80000001, exp: 32'h80000001};
    vecs[2] = '{tx: 32'h0F0F0F0F, exp: 32'h0F0F0F0F};
    vecs[3] = '{tx: 32'hFFFFFFFF, exp: 32'hFFFFFFFF};
    vecs[4] = '{tx: 32'h00000000, exp: 32'h00000000};
    vecs[5] = '{tx: 32'h55AA33CC, exp: 32'h55AA33CC};

    // reset state
    @(negedge clk);
    mon_on = 1'b1;
    tick(); #1;
    check("reset word_valid", 32'(word_valid), 32'd0);
    check("reset word_data", word_data, 32'd0);
    check("reset overflow", 32'(overflow), 32'd0);
    check("reset frame_err", 32'(frame_err), 32'd0);
    check("reset bit_cnt", 32'(bit_cnt), 32'd0);
    tick(); rst = 1'b0; enable = 1'b1;
    idle(6);

    // back-to-back words, ready tied high
    word_ready = 1'b1;
    acc_q.delete();
    o0 = ovf_seen; f0 = ferr_seen;
    send_word(32'hA5A51234, 1'b0);
    send_word(32'h0000FFFF, 1'b0);
    expect_word("b2b second", 32'h0000FFFF);
    idle(4);
    check("b2b count", acc_q.size(), 32'd2);
    if (acc_q.size() == 2) begin
      check("b2b word0", acc_q[0], 32'hA5A51234);
      check("b2b word1", acc_q[1], 32'h0000FFFF);
    end
    check("b2b no overflow", ovf_seen - o0, 32'd0);
    check("b2b no frame_err", ferr_seen - f0, 32'd0);

    // vector table
    foreach (vecs[i]) begin
      send_word(vecs[i].tx, 1'b0);
      expect_word($sformatf("vec%0d", i), vecs[i].exp);
      idle(2);
    end

    // backpressure
    word_ready = 1'b0;
    o0 = ovf_seen;
    send_word(32'hDEADBEEF, 1'b0);
    idle(4); #1;
    check("bp first valid", 32'(word_valid), 32'd1);
    check("bp first data", word_data, 32'hDEADBEEF);
    send_word(32'h12345678, 1'b0);
    idle(4); #1;
    check("bp held data", word_data, 32'hDEADBEEF);
    check("bp overflow pulses", ovf_seen - o0, 32'd1);
    tick(); word_ready = 1'b1;
    tick(); word_ready = 1'b0; #1;
    check("bp valid drop", 32'(word_valid), 32'd0);
    check("bp data kept", word_data, 32'hDEADBEEF);

    // completion and accept on the same edge
    send_word(32'h11111111, 1'b0);
    idle(4);
    o0 = ovf_seen;
    send_word(32'h22222222, 1'b0);
    while (edge_no < last_e - 1) idle(1);
    word_ready = 1'b1;
    idle(1);
    word_ready = 1'b0; #1;
    check("simul valid", 32'(word_valid), 32'd1);
    check("simul data", word_data, 32'h22222222);
    check("simul no overflow", ovf_seen - o0, 32'd0);

    // reset mid-word, with a word still held
    for (int i = 0; i < 17; i++) send_bit(1'(i & 1), 0);
    tick(); rst = 1'b1; ser_clk = 1'b0; ser_data = 1'b0;
    tick(); rst = 1'b0; #1;
    check("midrst word_valid", 32'(word_valid), 32'd0);
    check("midrst word_data", word_data, 32'd0);
    check("midrst bit_cnt", 32'(bit_cnt), 32'd0);
    check("midrst overflow", 32'(overflow), 32'd0);
    check("midrst frame_err", 32'(frame_err), 32'd0);
    idle(6);
    word_ready = 1'b1;
    send_word(32'h80000001, 1'b0);
    expect_word("post reset", 32'h80000001);

    // timeout
    f0 = ferr_seen;
    for (int i = 0; i < 10; i++) send_bit(1'b1, 0);
    o0 = last_e;
    idle(40); #1;
    check("timeout pulses", ferr_seen - f0, 32'd1);
    check("timeout edge", ferr_edge, o0 + TO);
    check("timeout bit_cnt", 32'(bit_cnt), 32'd0);
    send_word(32'hCAFEF00D, 1'b0);
    expect_word("after timeout", 32'hCAFEF00D);

    // enable low discards partial word silently
    f0 = ferr_seen;
    for (int i = 0; i < 5; i++) send_bit(1'b1, 0);
    idle(4); #1;
    check("en partial cnt", 32'(bit_cnt), 32'd5);
    tick(); enable = 1'b0;
    for (int i = 0; i < 3; i++) send_bit(1'b1, 0);
    idle(4); #1;
    check("en low cnt", 32'(bit_cnt), 32'd0);
    tick(); enable = 1'b1;
    idle(2);
    send_word(32'h0F0F0F0F, 1'b0);
    expect_word("en word", 32'h0F0F0F0F);
    idle(30);
    check("en no frame_err", ferr_seen - f0, 32'd0);

    // ser_clk already high at reset release
    tick(); rst = 1'b1; ser_clk = 1'b1;
    tick(); tick(); rst = 1'b0;
    repeat (8) tick();
    #1;
    check("hi-at-reset bit_cnt", 32'(bit_cnt), 32'd0);
    check("hi-at-reset valid", 32'(word_valid), 32'd0);
    idle(3);
    send_word(32'h3C3CA5A5, 1'b0);
    expect_word("hi-at-reset word", 32'h3C3CA5A5);

    // randomized words, gaps and backpressure against the model
    rand_ready = 1'b1;
    for (int n = 0; n < 40; n++) begin
      send_word(WIDTH'($urandom), 1'b1);
      idle(int'($urandom_range(0, 6)));
    end
    rand_ready = 1'b0;
    word_ready = 1'b1;
    idle(10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: run did not finish, %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sipo_rx.md
Name: sipo_rx

Overview:
- Serial-to-parallel receiver for the MSB-first data/clock serial link driven by the team's PISO transmitter.
- Oversamples the incoming serial clock and data on the system clock, and captures one bit per serial-clock rising edge.
- Assembles WIDTH-bit words and presents them through a one-entry valid/ready holding register.
- Sits on the readout side, between the link pins and the downstream word FIFO or packet logic.

Parameters:
- WIDTH, 32, bits per word; also sets bit_cnt width to clog2(WIDTH+1).
- SYNC_STAGES, 2, synchronizer depth applied identically to ser_clk and ser_data; minimum 2.
- TIMEOUT_CYCLES, 16, idle clk cycles allowed mid-word before the partial word is aborted; must be greater than 4.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous active-high reset.
- enable  in  1  receiver armed; when low, serial edges are ignored.
- ser_clk  in  1  serial clock from the transmitter; asynchronous, idles low.
- ser_data  in  1  serial data; changes while ser_clk is low and is stable across the ser_clk rising edge.
- word_data  out  WIDTH  received word, MSB = first bit received.
- word_valid  out  1  word_data holds an unread word.
- word_ready  in  1  consumer accepts the word when word_valid and word_ready are both high.
- overflow  out  1  one-cycle pulse: a completed word was dropped because the holding register was full.
- frame_err  out  1  one-cycle pulse: a partial word was aborted by timeout.
- bit_cnt  out  clog2(WIDTH+1)  bits captured in the current word (debug).

Behaviour:
- Reset, synchronous: all synchronizer flops, the edge-detect flop, the shift register, bit_cnt, the timeout counter, word_data, word_valid, overflow and frame_err go to 0.
- Synchronizers: ser_clk and ser_data each pass through SYNC_STAGES flops.
  - rise = sync_clk AND NOT sync_clk_prev, where sync_clk_prev is one further flop on sync_clk.
  - On a rise cycle, sync_data is sampled; equal synchronizer depth keeps the data aligned to the clock.
- Shift register: on each clk edge where rise AND enable, shift left by one, put sync_data into bit 0, and increment bit_cnt.
- Word completion: when rise AND enable AND bit_cnt == WIDTH-1, the completed word is {shift[WIDTH-2:0], sync_data}.
  - On that same edge, bit_cnt returns to 0 and the completed word is offered to the holding register.
- Latency: if edge k is the first clk edge at which ser_clk = 1 is sampled for the last bit, word_valid and word_data update at edge k+SYNC_STAGES.
- Holding register / handshake:
  - Empty: load the completed word and set word_valid.
  - Full with word_ready = 1 on the same edge: the old word is consumed and the new word loaded; word_valid stays 1.
  - Full with word_ready = 0: drop the new word, keep the old one, and pulse overflow for one cycle.
  - Accept without a new word: clear word_valid; word_data holds its last value.
  - word_data is stable while word_valid = 1 and word_ready = 0.
- Timeout:
  - The counter clears on every rise and whenever bit_cnt = 0; otherwise it increments each cycle.
  - When it reaches TIMEOUT_CYCLES: clear bit_cnt, clear the shift register and counter, and pulse frame_err for one cycle.
  - A rise on the same edge takes priority; no error is raised.
- Enable low: bit_cnt, shift register and timeout counter are held at 0. Any partial word is discarded silently, with no frame_err. The holding register and handshake keep operating.
- Serial timing: minimum serial bit period is 2 clk cycles (1 high, 1 low), which is the transmitter's rate. No rises are lost at this rate.
- Idle: the transmitter idles with ser_clk = 0 and ser_data = 0. A ser_clk already high at reset release produces no rise until it falls and rises again.
- Reset mid-word or mid-handshake discards everything; the next word is received correctly from its first bit.

Test Plan:
- Back-to-back words: transmitter-timed stream of 0xA5A51234 then 0x0000FFFF (2-cycle bit period), word_ready tied to 1 -> two word_valid pulses with those exact values; word_valid at edge k+2 after the 32nd ser_clk high is sampled; overflow = frame_err = 0.
- Backpressure: word_ready = 0 while 0xDEADBEEF then 0x12345678 arrive -> word_data stays 0xDEADBEEF, one overflow pulse when the second word completes. Then raise word_ready -> word_valid drops next edge.
- Simultaneous completion and accept: hold 0x11111111, pulse word_ready on the exact completion edge of 0x22222222 -> word_valid stays 1, word_data = 0x22222222, no overflow.
- Timeout: send 10 bits then 40 idle cycles -> frame_err pulses exactly TIMEOUT_CYCLES cycles after the last rise and bit_cnt returns to 0. A following full word 0xCAFEF00D is received intact.
- Reset mid-word: assert rst for 1 cycle after 17 bits -> all outputs 0 the next cycle; a subsequent word 0x80000001 is received correctly.
- Enable: deassert enable after 5 bits, reassert, send 0x0F0F0F0F -> no frame_err, received word = 0x0F0F0F0F; edges while enable = 0 leave bit_cnt at 0.
